// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
// Lock supervisor and loop-filter auto-tuner for a Gowin PLL with dynamic
// ICP/LPF selection. It sweeps charge-pump current (icpsel) and loop-filter
// resistance (lpfres) until one setting gives a lock that holds for
// STABLE_CYCLES cycles. It then watches that lock and relocks with the same
// setting whenever the lock drops. Runs on the free-running PLL reference clock.

module pll_lock_supervisor #(
  parameter int RST_CYCLES    = 64,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int ICP_MIN       = 8,
  parameter int ICP_STEP      = 8,
  parameter int ICP_MAX       = 48,
  parameter int LPFRES_MIN    = 0,
  parameter int LPFRES_MAX    = 7,
  parameter int LPFCAP        = 0,
  parameter int CNT_W         = 16
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       retune_req,
  output logic       pll_reset,
  output logic [5:0] icpsel,
  output logic [2:0] lpfres,
  output logic [1:0] lpfcap,
  output logic       clk_ok,
  output logic       fail,
  output logic [7:0] relock_cnt
);

  typedef enum logic [2:0] {
    ST_RESET_PLL,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_LOCKED,
    ST_FAIL
  } state_t;

  // Terminal timer values; each phase clears the timer on entry and counts
  // up, so the phase ends when the timer holds its length minus one.
  localparam logic [CNT_W-1:0] RstLast     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] StableLast  = CNT_W'(STABLE_CYCLES - 1);

  // Sweep limits. The icpsel step is evaluated in 7 bits so that a sum
  // beyond 63 is seen as "past the end" instead of wrapping back to a
  // small value.
  localparam logic [6:0] IcpStep7 = 7'(ICP_STEP);
  localparam logic [6:0] IcpMax7  = 7'(ICP_MAX);
  localparam logic [5:0] IcpMin6  = 6'(ICP_MIN);
  localparam logic [2:0] LpfMin3  = 3'(LPFRES_MIN);
  localparam logic [2:0] LpfMax3  = 3'(LPFRES_MAX);
  localparam logic [1:0] LpfCap2  = 2'(LPFCAP);

  logic             lockMeta_q;
  logic             lockSync_q;

  state_t           state_q;
  logic [CNT_W-1:0] timer_q;
  logic             pllReset_q;
  logic [5:0]       icpsel_q;
  logic [2:0]       lpfres_q;
  logic [1:0]       lpfcap_q;
  logic             clkOk_q;
  logic             fail_q;
  logic [7:0]       relockCnt_q;

  logic [6:0]       icpSum_d;
  logic [5:0]       advIcp_d;
  logic [2:0]       advLpf_d;
  state_t           advState_d;

  // Two-flop synchroniser bringing the asynchronous PLL LOCK into clkin.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      lockMeta_q <= 1'b0;
      lockSync_q <= 1'b0;
    end else begin
      lockMeta_q <= pll_lock;
      lockSync_q <= lockMeta_q;
    end
  end

  // Next sweep setting after a failed attempt: step icpsel first, then wrap
  // icpsel and step lpfres, and give up once both ranges are exhausted.
  always_comb begin
    icpSum_d   = {1'b0, icpsel_q} + IcpStep7;
    advIcp_d   = icpsel_q;
    advLpf_d   = lpfres_q;
    advState_d = ST_RESET_PLL;
    if (icpSum_d <= IcpMax7) begin
      advIcp_d = icpSum_d[5:0];
    end else if (lpfres_q < LpfMax3) begin
      advIcp_d = IcpMin6;
      advLpf_d = lpfres_q + 3'd1;
    end else begin
      advState_d = ST_FAIL;
    end
  end

  // Supervisor FSM with registered outputs. A retune request overrides every
  // other event in the same cycle; icpsel/lpfres only move on the edge that
  // enters RESET_PLL or FAIL, so they never change while the PLL is running.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RESET_PLL;
      timer_q     <= '0;
      pllReset_q  <= 1'b1;
      icpsel_q    <= IcpMin6;
      lpfres_q    <= LpfMin3;
      lpfcap_q    <= LpfCap2;
      clkOk_q     <= 1'b0;
      fail_q      <= 1'b0;
      relockCnt_q <= 8'd0;
    end else if (retune_req) begin
      state_q    <= ST_RESET_PLL;
      timer_q    <= '0;
      pllReset_q <= 1'b1;
      icpsel_q   <= IcpMin6;
      lpfres_q   <= LpfMin3;
      clkOk_q    <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      lpfcap_q <= LpfCap2;
      case (state_q)
        ST_RESET_PLL: begin
          pllReset_q <= 1'b1;
          if (timer_q == RstLast) begin
            state_q    <= ST_WAIT_LOCK;
            pllReset_q <= 1'b0;
            timer_q    <= '0;
          end else begin
            timer_q <= timer_q + CNT_W'(1);
          end
        end

        ST_WAIT_LOCK: begin
          if (lockSync_q) begin
            state_q <= ST_STABLE;
            timer_q <= '0;
          end else if (timer_q == TimeoutLast) begin
            state_q    <= advState_d;
            icpsel_q   <= advIcp_d;
            lpfres_q   <= advLpf_d;
            pllReset_q <= 1'b1;
            fail_q     <= (advState_d == ST_FAIL);
            timer_q    <= '0;
          end else begin
            timer_q <= timer_q + CNT_W'(1);
          end
        end

        ST_STABLE: begin
          if (!lockSync_q) begin
            state_q    <= advState_d;
            icpsel_q   <= advIcp_d;
            lpfres_q   <= advLpf_d;
            pllReset_q <= 1'b1;
            fail_q     <= (advState_d == ST_FAIL);
            timer_q    <= '0;
          end else if (timer_q == StableLast) begin
            state_q <= ST_LOCKED;
            clkOk_q <= 1'b1;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + CNT_W'(1);
          end
        end

        ST_LOCKED: begin
          if (!lockSync_q) begin
            state_q    <= ST_RESET_PLL;
            clkOk_q    <= 1'b0;
            pllReset_q <= 1'b1;
            timer_q    <= '0;
            if (relockCnt_q != 8'hFF) begin
              relockCnt_q <= relockCnt_q + 8'd1;
            end
          end
        end

        ST_FAIL: begin
          fail_q     <= 1'b1;
          pllReset_q <= 1'b1;
          clkOk_q    <= 1'b0;
        end

        default: begin
          state_q    <= ST_RESET_PLL;
          timer_q    <= '0;
          pllReset_q <= 1'b1;
          clkOk_q    <= 1'b0;
        end
      endcase
    end
  end

  assign pll_reset  = pllReset_q;
  assign icpsel     = icpsel_q;
  assign lpfres     = lpfres_q;
  assign lpfcap     = lpfcap_q;
  assign clk_ok     = clkOk_q;
  assign fail       = fail_q;
  assign relock_cnt = relockCnt_q;

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Lock supervisor and loop-filter auto-tuner for a Gowin PLL instantiated with dynamic ICP/LPF selection. It drives the PLL's RESET, ICPSEL, LPFRES and LPFCAP inputs and watches LOCK. It sweeps charge-pump current and loop-filter resistance until a setting gives a stable lock, then supervises that lock and relocks on loss. It sits beside the PLL wrapper in the ethernet clocking path and runs on the free-running PLL reference clock.

## Interface
- RST_CYCLES, 64: cycles pll_reset is held high per attempt (≥2)
- LOCK_TIMEOUT, 50000: cycles allowed from reset release to first lock
- STABLE_CYCLES, 1024: consecutive locked cycles needed to accept a setting
- ICP_MIN, 8: first icpsel value of the sweep
- ICP_STEP, 8: icpsel increment
- ICP_MAX, 48: last icpsel value (≤63)
- LPFRES_MIN, 0: first lpfres value
- LPFRES_MAX, 7: last lpfres value
- LPFCAP, 0: constant lpfcap value
- CNT_W, 16: timer width; must hold max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)

Ports:
- clkin  in  1  reference clock; all logic on its rising edge
- reset  in  1  asynchronous, active-high reset
- pll_lock  in  1  PLL LOCK; asynchronous, synchronised internally
- retune_req  in  1  single-cycle pulse; restarts the sweep from the first setting
- pll_reset  out  1  to PLL RESET
- icpsel  out  6  to PLL ICPSEL
- lpfres  out  3  to PLL LPFRES
- lpfcap  out  2  to PLL LPFCAP; always LPFCAP
- clk_ok  out  1  PLL locked and accepted
- fail  out  1  every setting exhausted without a stable lock
- relock_cnt  out  8  count of lock losses in LOCKED, saturating at 255

## Operation
- pll_lock passes through a 2-FF synchroniser to give lock_s. All outputs are registered.
- Reset values: state RESET_PLL, timer 0, pll_reset=1, icpsel=ICP_MIN, lpfres=LPFRES_MIN, lpfcap=LPFCAP, clk_ok=0, fail=0, relock_cnt=0.
- The FSM has five states: RESET_PLL, WAIT_LOCK, STABLE, LOCKED and FAIL.
- **RESET_PLL**
  - pll_reset=1 for exactly RST_CYCLES cycles.
  - Then go to WAIT_LOCK with pll_reset=0 and the timer cleared.
- **WAIT_LOCK**
  - If lock_s=1, go to STABLE with the timer cleared.
  - If the timer reaches LOCK_TIMEOUT-1 with no lock, perform ADVANCE.
- **STABLE**
  - If lock_s stays 1 for STABLE_CYCLES consecutive cycles, go to LOCKED.
  - Any lock_s=0 performs ADVANCE.
- **LOCKED**
  - clk_ok=1.
  - If lock_s=0, clear clk_ok, increment relock_cnt (saturating), and go to RESET_PLL with the setting unchanged.
- **FAIL**
  - fail=1 and pll_reset=1; the FSM stays here.
- **ADVANCE**
  - If icpsel+ICP_STEP ≤ ICP_MAX, step icpsel by ICP_STEP.
  - Otherwise, if lpfres < LPFRES_MAX, set icpsel=ICP_MIN and lpfres=lpfres+1.
  - Otherwise go to FAIL.
  - In the non-FAIL cases, go to RESET_PLL.
  - Compare in 7 bits so icpsel never wraps.
- icpsel and lpfres change only on the cycle that enters RESET_PLL or FAIL. They are never changed while pll_reset=0.
- **retune_req** (accepted in any state)
  - Sets icpsel=ICP_MIN, lpfres=LPFRES_MIN, clk_ok=0, fail=0, and goes to RESET_PLL.
  - relock_cnt is not cleared.
  - retune_req has priority over any lock or timeout event in the same cycle.
- Asserting reset mid-operation immediately restores all reset values, including pll_reset=1.

## Timing
- Lock-detect latency is 2 cycles from a pll_lock edge to lock_s, plus 1 cycle to the FSM reaction.
- pll_reset falls RST_CYCLES cycles after entering RESET_PLL.
- clk_ok rises exactly STABLE_CYCLES cycles after STABLE is entered, provided lock_s stays high.
- On lock loss in LOCKED:
  - clk_ok falls, pll_reset rises and relock_cnt increments, all on the same edge.
  - That edge is 3 cycles after pll_lock falls.
- retune_req takes effect on the next edge: clk_ok=0 and pll_reset=1 one cycle after the pulse.
- A pll_lock glitch shorter than 1 cycle may be missed. A glitch lasting 2 or more cycles is always seen.

## Test plan
Parameters for all scenarios: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, ICP_MIN=8, ICP_STEP=8, ICP_MAX=24, LPFRES_MIN=2, LPFRES_MAX=3.

1. **Immediate lock:** pll_lock=1 held from 2 cycles after pll_reset falls.
   - pll_reset is high for exactly 4 cycles.
   - clk_ok=1 with icpsel=8, lpfres=2, fail=0.
2. **Timeout sweep:** pll_lock never asserts.
   - icpsel/lpfres step through 8/2, 16/2, 24/2, 8/3, 16/3, 24/3.
   - Each attempt is 4 reset cycles plus 20 wait cycles.
   - Then fail=1, pll_reset=1, clk_ok=0.
3. **Unstable lock:**
   - Stimulus: pll_lock high for 5 cycles then low at setting 8/2; pll_lock held high from setting 16/2 onward.
   - ADVANCE to icpsel=16, then clk_ok=1 at icpsel=16, lpfres=2.
4. **Lock loss:** in LOCKED, drop pll_lock for 3 cycles, then hold it high.
   - relock_cnt goes 0→1 and clk_ok falls.
   - The setting is unchanged.
   - clk_ok=1 again after 4 reset cycles plus 8 stable cycles.
5. **Retune and reset:**
   - retune_req in FAIL: fail=0 and the sweep restarts at 8/2.
   - retune_req on the same cycle as a timeout: the retune wins, giving icpsel=8 rather than the next setting.
   - Asserting reset in STABLE immediately gives all reset values.
6. **Saturation:** force 260 lock losses; relock_cnt reads 255.
